// File: rtl/bb_stream_source.sv
// Baseband sample stream source: buffers locally produced samples and sends each frame
// out as one CYC_O/STB_O burst with ACK_I backpressure and a forced CYC_O gap between frames.
//
//   state | meaning
//   IDLE  | no frame open; enter BURST once the output register holds a sample
//   BURST | CYC_O high; present output register whenever valid
//   GAP   | single CYC_O-low cycle after a frame's last sample is accepted
module bb_stream_source #(
    parameter int ADDR_W = 4
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              SRC_WE,
    input  logic [31:0]       SRC_DAT,
    input  logic              SRC_LAST,
    output logic              SRC_FULL,
    output logic              SRC_OVF,
    output logic [ADDR_W:0]   LEVEL,
    output logic [31:0]       DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    output logic [15:0]       FRM_CNT
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [32:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] level;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            xfer;
    logic            ovalid;
    logic            olast;
    logic            ovalid_nxt;
    logic            cyc_r;
    logic            stb_r;
    logic [31:0]     dat_r;
    logic            ovf_r;
    logic [15:0]     frm_cnt_r;
    logic [32:0]     head;

    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (level == '0);
    assign SRC_FULL   = (level == DEPTH_L);
    assign push       = SRC_WE & ~SRC_FULL;
    assign xfer       = stb_r & ACK_I;
    assign pop        = ~fifo_empty & (~ovalid | xfer);
    assign head       = mem[rd_ptr[ADDR_W-1:0]];

    // Output register validity after this edge; drives STB_O's registered value.
    always_comb begin
        ovalid_nxt = ovalid;
        if (pop) begin
            ovalid_nxt = 1'b1;
        end else if (xfer) begin
            ovalid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {SRC_LAST, SRC_DAT};
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_r  <= 1'b0;
            ovalid <= 1'b0;
            olast  <= 1'b0;
            dat_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (SRC_WE & SRC_FULL) begin
                ovf_r <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                olast  <= head[32];
                dat_r  <= head[31:0];
            end
            ovalid <= ovalid_nxt;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= IDLE;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            frm_cnt_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ovalid) begin
                        state <= BURST;
                        cyc_r <= 1'b1;
                        stb_r <= ovalid_nxt;
                    end else begin
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
                    end
                end
                BURST: begin
                    // A sample preloaded on the closing transfer waits for the next frame.
                    if (xfer & olast) begin
                        state     <= GAP;
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        frm_cnt_r <= frm_cnt_r + 16'd1;
                    end else begin
                        cyc_r <= 1'b1;
                        stb_r <= ovalid_nxt;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    cyc_r <= 1'b0;
                    stb_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cyc_r <= 1'b0;
                    stb_r <= 1'b0;
                end
            endcase
        end
    end

    assign LEVEL   = level;
    assign SRC_OVF = ovf_r;
    assign DAT_O   = dat_r;
    assign CYC_O   = cyc_r;
    assign WE_O    = cyc_r;
    assign STB_O   = stb_r;
    assign FRM_CNT = frm_cnt_r;

endmodule

// File: tb/tb_bb_stream_source.sv
// Bench for bb_stream_source: directed frames plus a random phase, checked against a queue of
// accepted samples and a frame-level model of CYC_O, gaps and the frame counter.
module tb_bb_stream_source;

    localparam int ADDR_W = 4;

    logic              CLK_I = 1'b0;
    logic              RST_I;
    logic              SRC_WE;
    logic [31:0]       SRC_DAT;
    logic              SRC_LAST;
    logic              SRC_FULL;
    logic              SRC_OVF;
    logic [ADDR_W:0]   LEVEL;
    logic [31:0]       DAT_O;
    logic              CYC_O;
    logic              STB_O;
    logic              WE_O;
    logic              ACK_I;
    logic [15:0]       FRM_CNT;

    bb_stream_source #(.ADDR_W(ADDR_W)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .SRC_WE(SRC_WE), .SRC_DAT(SRC_DAT),
        .SRC_LAST(SRC_LAST), .SRC_FULL(SRC_FULL), .SRC_OVF(SRC_OVF), .LEVEL(LEVEL),
        .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
        .FRM_CNT(FRM_CNT)
    );

    always #5 CLK_I = ~CLK_I;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q[$];
    logic [15:0] frm_exp = '0;
    bit          in_frame = 0;
    int          low_req = 0;
    int          low_run = 0;
    int          last_gap = -1;
    bit          prev_cyc = 0;
    int          xfers = 0;

    localparam logic [32:0] SENTINEL = 33'h1_DEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        was_xfer;
        logic        was_hold;
        logic        rst_now;
        logic [31:0] d;
        logic [32:0] e;
        was_xfer = STB_O & ACK_I;
        was_hold = STB_O & ~ACK_I;
        rst_now  = RST_I;
        d        = DAT_O;
        @(posedge CLK_I);
        #1;
        if (rst_now) begin
            q.delete();
            frm_exp  = '0;
            in_frame = 0;
            low_req  = 0;
            low_run  = 0;
            prev_cyc = 0;
            chk("rst_cyc", 32'(CYC_O), 0);
            chk("rst_stb", 32'(STB_O), 0);
            chk("rst_we", 32'(WE_O), 0);
            chk("rst_dat", DAT_O, 0);
            chk("rst_level", 32'(LEVEL), 0);
            chk("rst_frm", 32'(FRM_CNT), 0);
            chk("rst_ovf", 32'(SRC_OVF), 0);
            chk("rst_full", 32'(SRC_FULL), 0);
            return;
        end
        if (was_xfer) begin
            xfers++;
            e = (q.size() > 0) ? q.pop_front() : SENTINEL;
            chk("xfer_dat", d, e[31:0]);
            if (e[32]) begin
                frm_exp  = frm_exp + 16'd1;
                in_frame = 0;
                low_req  = 2;
            end else begin
                in_frame = 1;
            end
        end
        if (was_hold) chk("hold_stb", 32'(STB_O), 1);
        if (STB_O) begin
            e = (q.size() > 0) ? q[0] : SENTINEL;
            chk("present_dat", DAT_O, e[31:0]);
        end
        if (q.size() == 0) chk("stb_empty", 32'(STB_O), 0);
        chk("we_eq_cyc", 32'(WE_O), 32'(CYC_O));
        chk("frm_cnt", 32'(FRM_CNT), 32'(frm_exp));
        if (low_req > 0) begin
            chk("gap_low", 32'(CYC_O), 0);
            low_req--;
        end else if (in_frame) begin
            chk("cyc_in_frame", 32'(CYC_O), 1);
        end
        if (!CYC_O) low_run++;
        if (CYC_O && !prev_cyc) last_gap = low_run;
        if (CYC_O) low_run = 0;
        prev_cyc = CYC_O;
    endtask

    task automatic push(input logic [31:0] d, input logic last, input bit accept);
        SRC_WE   = 1'b1;
        SRC_DAT  = d;
        SRC_LAST = last;
        if (accept) q.push_back({last, d});
        step();
        SRC_WE   = 1'b0;
        SRC_LAST = 1'b0;
    endtask

    task automatic drain();
        ACK_I = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && !CYC_O && low_req == 0) break;
            step();
        end
        chk("drain_q_empty", q.size(), 0);
        chk("drain_cyc_low", 32'(CYC_O), 0);
    endtask

    task automatic frame4();
        push(32'h0001_0001, 1'b0, 1);
        chk("lat_cyc_n", 32'(CYC_O), 0);
        push(32'h0002_0002, 1'b0, 1);
        chk("lat_cyc_n1", 32'(CYC_O), 0);
        push(32'h0003_0003, 1'b0, 1);
        chk("lat_cyc_n2", 32'(CYC_O), 1);
        chk("lat_stb_n2", 32'(STB_O), 1);
        chk("lat_dat_n2", DAT_O, 32'h0001_0001);
        push(32'h0004_0004, 1'b1, 1);
    endtask

    initial begin
        logic [15:0] f0;
        int          x0;
        RST_I    = 1'b1;
        SRC_WE   = 1'b0;
        SRC_DAT  = '0;
        SRC_LAST = 1'b0;
        ACK_I    = 1'b1;
        step();
        step();
        RST_I = 1'b0;
        step();

        // 1: basic 4-sample frame
        x0 = xfers;
        frame4();
        drain();
        chk("t1_xfers", xfers - x0, 4);
        chk("t1_frm", 32'(FRM_CNT), 1);

        // 2: backpressure on 2nd sample
        x0 = xfers;
        frame4();
        ACK_I = 1'b0;
        repeat (3) step();
        chk("t2_hold_dat", DAT_O, 32'h0002_0002);
        chk("t2_hold_stb", 32'(STB_O), 1);
        drain();
        chk("t2_xfers", xfers - x0, 4);

        // 3: underrun mid-frame
        f0 = FRM_CNT;
        x0 = xfers;
        push(32'h0011_0011, 1'b0, 1);
        push(32'h0012_0012, 1'b0, 1);
        repeat (5) step();
        chk("t3_cyc_underrun", 32'(CYC_O), 1);
        chk("t3_stb_underrun", 32'(STB_O), 0);
        push(32'h0013_0013, 1'b0, 1);
        push(32'h0014_0014, 1'b1, 1);
        drain();
        chk("t3_xfers", xfers - x0, 4);
        chk("t3_frm_delta", 32'(FRM_CNT - f0), 1);

        // 4: overflow with ACK_I held low
        ACK_I = 1'b0;
        x0 = xfers;
        for (int i = 1; i <= 20; i++) begin
            push(32'h0100_0000 + 32'(i), (i == 17), (i <= 17));
            if (i == 16) chk("t4_full_at15", 32'(SRC_FULL), 0);
            if (i == 17) begin
                chk("t4_full_at16", 32'(SRC_FULL), 1);
                chk("t4_ovf_before_drop", 32'(SRC_OVF), 0);
            end
        end
        chk("t4_level", 32'(LEVEL), 16);
        chk("t4_full", 32'(SRC_FULL), 1);
        chk("t4_ovf", 32'(SRC_OVF), 1);
        drain();
        chk("t4_xfers", xfers - x0, 17);
        chk("t4_ovf_sticky", 32'(SRC_OVF), 1);

        // 5: two preloaded back-to-back frames
        f0 = FRM_CNT;
        ACK_I = 1'b0;
        for (int i = 1; i <= 6; i++) push(32'h0200_0000 + 32'(i), (i == 3 || i == 6), 1);
        drain();
        chk("t5_gap", last_gap, 2);
        chk("t5_frm_delta", 32'(FRM_CNT - f0), 2);

        // 6: reset during 2nd transfer, then a clean frame
        push(32'h0301_0301, 1'b0, 1);
        push(32'h0302_0302, 1'b0, 1);
        push(32'h0303_0303, 1'b0, 1);
        push(32'h0304_0304, 1'b1, 1);
        RST_I = 1'b1;
        step();
        RST_I = 1'b0;
        step();
        x0 = xfers;
        frame4();
        drain();
        chk("t6_xfers", xfers - x0, 4);
        chk("t6_frm", 32'(FRM_CNT), 1);

        // random frames, backpressure and push gaps; outstanding kept below capacity
        for (int c = 0; c < 600; c++) begin
            ACK_I = ($urandom_range(0, 3) != 0);
            if (q.size() < 12 && $urandom_range(0, 2) != 0)
                push($urandom, ($urandom_range(0, 3) == 0), 1);
            else
                step();
        end
        push($urandom, 1'b1, 1);
        drain();
        chk("rand_ovf_clear", 32'(SRC_OVF), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
